// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file scoreboard.
//   NREG    : number of architectural registers (x0 hard-wired zero)
//   REG_W   : register index width
//   MAX_LAT : longest issue-to-write-back latency
//   LAT_W   : latency field width
//   CNT_W   : stall statistics counter width
//   slot_t  : one write-back slot {valid, destination register}
package regfile_pkg;
  localparam int NREG    = 32;
  localparam int REG_W   = 5;
  localparam int MAX_LAT = 4;
  localparam int LAT_W   = 3;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
  } slot_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue / write-back bundle between the issue stage and the scoreboard.
//   master : issue stage (drives issue_*, observes ready, write-back, status)
//   slave  : scoreboard (drives issue_ready, wb_*, busy_vec, stall_cnt)
interface regfile_scoreboard_if;
  import regfile_pkg::*;

  logic             issue_valid;
  logic             issue_ready;
  logic [REG_W-1:0] issue_rs1;
  logic [REG_W-1:0] issue_rs2;
  logic             issue_use_rs1;
  logic             issue_use_rs2;
  logic [REG_W-1:0] issue_rd;
  logic             issue_rd_we;
  logic [LAT_W-1:0] issue_lat;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic [NREG-1:0]  busy_vec;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_rd_we, issue_lat,
    input  issue_ready, wb_valid, wb_rd, busy_vec, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_rd_we, issue_lat,
    output issue_ready, wb_valid, wb_rd, busy_vec, stall_cnt
  );
endinterface

// File: rtl/regfile_wb_slot_pipe.sv
// Shifting write-back slot pipeline with insert port and busy decoder.
// Slot k holds the write that retires k-1 cycles from now; slot 1 is the
// write-back happening this cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   i_ins_en   : insert a write this cycle
//   i_ins_lat  : slot index to insert into (1..MAX_LAT)
//   i_ins_rd   : destination register of the inserted write
//   o_wb_valid : write strobe (slot 1 valid)
//   o_wb_rd    : write address (0 when no write)
//   o_busy_vec : per-register pending-write flag, bit 0 forced 0
//   o_slot_v   : slot valid bits 1..MAX_LAT+1 (top entry always empty)
module regfile_wb_slot_pipe
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ins_en,
  input  logic [LAT_W-1:0]   i_ins_lat,
  input  logic [REG_W-1:0]   i_ins_rd,
  output logic               o_wb_valid,
  output logic [REG_W-1:0]   o_wb_rd,
  output logic [NREG-1:0]    o_busy_vec,
  output logic [MAX_LAT+1:1] o_slot_v
);

  slot_t r_slot      [1:MAX_LAT];
  slot_t w_slot_next [1:MAX_LAT];

  for (genvar gi = 1; gi <= MAX_LAT; gi++) begin : g_slot
    slot_t w_shift;
    if (gi < MAX_LAT) begin : g_mid
      assign w_shift = r_slot[gi+1];
    end else begin : g_top
      assign w_shift = '0;
    end
    // The port check upstream guarantees w_shift is empty when we insert.
    assign w_slot_next[gi] = (i_ins_en && (i_ins_lat == LAT_W'(gi)))
                           ? slot_t'{v: 1'b1, rd: i_ins_rd}
                           : w_shift;
    assign o_slot_v[gi] = r_slot[gi].v;
  end

  assign o_slot_v[MAX_LAT+1] = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= MAX_LAT; k++) begin
        r_slot[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= MAX_LAT; k++) begin
        r_slot[k] <= w_slot_next[k];
      end
    end
  end

  assign o_wb_valid = r_slot[1].v;
  assign o_wb_rd    = r_slot[1].v ? r_slot[1].rd : '0;

  // The slot being written back this cycle still counts as busy.
  always_comb begin
    o_busy_vec = '0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (r_slot[k].v) begin
        o_busy_vec[r_slot[k].rd] = 1'b1;
      end
    end
    o_busy_vec[0] = 1'b0;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-stage scoreboard for a 2-read/1-write register file.
// Blocks issue on RAW, WAW, write-port collision or illegal latency, and
// schedules the single write port for fixed-latency units.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : issue request/ready, write-back strobe/address,
//              busy vector and saturating stall counter
module regfile_scoreboard
  import regfile_pkg::*;
(
  input logic                 CLK,
  input logic                 RST,
  regfile_scoreboard_if.slave bus
);

  logic [NREG-1:0]    w_busy;
  logic [MAX_LAT+1:1] w_slot_v;
  logic               w_alloc;
  logic               w_lat_ok;
  logic               w_raw;
  logic               w_waw;
  logic               w_port;
  logic               w_ready;
  logic               w_fire;
  logic [CNT_W-1:0]   r_stall_cnt;

  // Writes to x0 or instructions without a destination take no slot.
  assign w_alloc  = bus.issue_rd_we & (bus.issue_rd != '0);
  assign w_lat_ok = (bus.issue_lat >= LAT_W'(1)) &
                    (bus.issue_lat <= LAT_W'(MAX_LAT));

  assign w_raw = (bus.issue_use_rs1 & (bus.issue_rs1 != '0) & w_busy[bus.issue_rs1]) |
                 (bus.issue_use_rs2 & (bus.issue_rs2 != '0) & w_busy[bus.issue_rs2]);
  assign w_waw = w_alloc & w_busy[bus.issue_rd];

  // Slot lat+1 shifts into slot lat on this edge; if it is occupied the
  // new write would share a write-back cycle with it.
  always_comb begin
    w_port = 1'b0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (bus.issue_lat == LAT_W'(k)) begin
        w_port = w_alloc & w_slot_v[k+1];
      end
    end
  end

  assign w_ready = ~RST & ~w_raw & ~w_waw & ~w_port & w_lat_ok;
  assign w_fire  = bus.issue_valid & w_ready;

  regfile_wb_slot_pipe u_slot_pipe (
    .clk        (CLK),
    .rst        (RST),
    .i_ins_en   (w_fire & w_alloc),
    .i_ins_lat  (bus.issue_lat),
    .i_ins_rd   (bus.issue_rd),
    .o_wb_valid (bus.wb_valid),
    .o_wb_rd    (bus.wb_rd),
    .o_busy_vec (w_busy),
    .o_slot_v   (w_slot_v)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (bus.issue_valid && !w_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.issue_ready = w_ready;
  assign bus.busy_vec    = w_busy;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Issue-stage controller for the 2-read/1-write register file in ID:EX. It tracks in-flight writes per architectural register and blocks issue on RAW or WAW hazards, or on a write-port collision. It also generates the write-back strobe (`RegWrite`) and the write address (`rd`) for the register file in the correct cycle. Fixed-latency functional units report latency at issue; the scoreboard owns write-port scheduling.

Parameters:
- NREG, 32, number of architectural registers; x0 is hard-wired zero.
- REG_W, 5, register index width (log2 NREG).
- MAX_LAT, 4, maximum issue-to-write-back latency in cycles.
- LAT_W, 3, width of the latency field; must hold MAX_LAT.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- CLK, in, 1, clock; all state updates on the rising edge.
- RST, in, 1, asynchronous active-high reset.
- issue_valid, in, 1, instruction presented for issue.
- issue_ready, out, 1, combinational; the instruction may issue this cycle.
- issue_rs1, in, REG_W, first source register.
- issue_rs2, in, REG_W, second source register.
- issue_use_rs1, in, 1, the instruction reads rs1.
- issue_use_rs2, in, 1, the instruction reads rs2.
- issue_rd, in, REG_W, destination register.
- issue_rd_we, in, 1, the instruction writes rd.
- issue_lat, in, LAT_W, cycles from issue to write-back; legal range 1..MAX_LAT.
- wb_valid, out, 1, `RegWrite` strobe to the register file this cycle.
- wb_rd, out, REG_W, write address to the register file this cycle.
- busy_vec, out, NREG, per-register pending-write flag; bit 0 is always 0.
- stall_cnt, out, CNT_W, saturating count of stalled cycles.

Behaviour:
- Clock and reset: one clock (`CLK`); reset (`RST`) is asynchronous and active-high.
- Reset: all slots cleared; wb_valid=0, wb_rd=0, busy_vec=0, stall_cnt=0. issue_ready is forced to 0 while RST=1.
- Reset mid-operation: all in-flight writes are discarded, and no wb_valid is produced for them after RST deasserts.
- Slot pipeline state: slot[1..MAX_LAT], each holding {v, rd}.
  - wb_valid = slot[1].v.
  - wb_rd = slot[1].rd when valid, else 0.
- Each edge:
  - slot[k] <= slot[k+1] for k < MAX_LAT.
  - slot[MAX_LAT] <= empty.
  - On fire with allocation, slot[issue_lat] <= {1, issue_rd}; this overrides the shifted value, which is guaranteed empty by the port check.
- fire = issue_valid & issue_ready.
- alloc = issue_rd_we & (issue_rd != 0).
  - No slot is allocated when rd_we=0 or rd=x0.
  - Those instructions are checked only for RAW hazards.
- busy[r] = OR over k of (slot[k].v & slot[k].rd == r).
- issue_ready = !RST & !raw & !waw & !port & lat_ok, where:
  - raw = (use_rs1 & rs1 != 0 & busy[rs1]) | (use_rs2 & rs2 != 0 & busy[rs2]).
  - waw = alloc & busy[rd].
  - port = alloc & slot[issue_lat+1].v, with slot[MAX_LAT+1] defined as empty.
  - lat_ok = (issue_lat >= 1) & (issue_lat <= MAX_LAT); an illegal latency stalls indefinitely.
- Timing: a fire in cycle t with latency L gives wb_valid=1 and wb_rd=rd in cycle t+L.
  - busy[rd] is 1 in cycles t+1 through t+L inclusive.
  - A dependent instruction can fire no earlier than cycle t+L+1; there is no bypass.
- Single write port: at most one wb_valid per cycle, guaranteed by the port check.
- Same-cycle events:
  - A register being written back (slot[1]) is still busy in that cycle.
  - A new allocation to the same rd in that cycle is blocked by waw.
- stall_cnt increments each cycle with issue_valid & !issue_ready & !RST, and saturates at all-ones.
- issue_ready is combinational from the inputs and state; all other outputs are registered or decoded from state.

Decomposition:
- Package regfile_pkg holds:
  - Constants NREG, REG_W, MAX_LAT, LAT_W.
  - Slot struct {logic v; logic [REG_W-1:0] rd}.
- One natural sub-module, regfile_wb_slot_pipe: the shifting slot array with an insert port and a busy decoder.
- Hazard logic and the stall counter stay in the top module.

Test Plan:
1. RAW stall:
   - Stimulus: fire rd=3, lat=3 at cycle 0; at cycle 1 issue rs1=3, use_rs1=1.
   - Required: issue_ready=0 in cycles 1–3; wb_valid=1 with wb_rd=3 at cycle 3; fire at cycle 4; stall_cnt=3.
2. WAW stall:
   - Stimulus: fire rd=5, lat=2; next cycle issue rd=5, lat=1.
   - Required: blocked until cycle 3; second write-back at cycle 4.
3. Port conflict:
   - Stimulus: fire rd=1, lat=3 at cycle 0; issue rd=2, lat=2 at cycle 1.
   - Required: stall at cycle 1; fire at cycle 2; wb_rd=1 at cycle 3; wb_rd=2 at cycle 4; never two strobes in one cycle.
4. x0 and no-write instructions:
   - Stimulus: issue rd=0 with rd_we=1 and lat=1, back-to-back with an instruction reading rs1=0.
   - Required: both fire immediately; wb_valid stays 0; busy_vec stays 0.
5. Reset mid-flight:
   - Stimulus: fire rd=7, lat=4; assert RST asynchronously at cycle 2.
   - Required: wb_valid=0 and busy_vec=0 immediately and after release; no write-back for rd 7.
6. Illegal latency and saturation:
   - Stimulus: issue_valid=1 with lat=0 held for 2^CNT_W+5 cycles.
   - Required: issue_ready=0 throughout; stall_cnt sticks at 0xFFFF.
